// File: rtl/riscv_id.sv
// Decode stage: IF/ID register, 32x32 register file with write-through, immediate decode, load-use and JAL control.
// Latency: one cycle from IF/ID to the ID/EX outputs; stall, JAL redirect and target are combinational from IF/ID.
// Backpressure: a load-use hazard holds IF/ID for one cycle and inserts an ID/EX bubble; i_ex_jmp flushes both registers.
module riscv_id #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_ex_jmp,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_id_jmp,
  output logic [31:0] o_id_target,
  output logic        o_stall,
  output logic        o_ex_valid,
  output logic [31:0] o_ex_pc,
  output logic [6:0]  o_ex_opcode,
  output logic [2:0]  o_ex_funct3,
  output logic        o_ex_funct7b5,
  output logic [4:0]  o_ex_rs1,
  output logic [4:0]  o_ex_rs2,
  output logic [4:0]  o_ex_rd,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output logic [31:0] o_ex_imm,
  output logic        o_ex_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal;
  } idex_t;

  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  idex_t       idex_q, idex_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, imm_j, rs1_data, rs2_data;
  logic        illegal, rs1_used, rs2_used;

  assign opcode = ifid_instr_q[6:0];
  assign rd     = ifid_instr_q[11:7];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];
  assign imm_j  = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                   ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

  // Immediate format, operand usage and legality selected by opcode
  always_comb begin
    imm      = '0;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm      = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
        rs1_used = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: imm = {ifid_instr_q[31:12], 12'h000};
      OP_JAL:           imm = imm_j;
      OP_R: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Register reads; a same-cycle writeback to a nonzero register is forwarded
  always_comb begin
    rs1_data = regs_q[rs1];
    rs2_data = regs_q[rs2];
    if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs1)) rs1_data = i_wb_data;
    if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs2)) rs2_data = i_wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  // Load-use hazard and decode-stage JAL redirect; an execute redirect overrides both
  always_comb begin
    o_stall = ifid_valid_q && idex_q.valid && (idex_q.opcode == OP_LOAD) && (idex_q.rd != 5'd0) &&
              ((rs1_used && (rs1 == idex_q.rd)) || (rs2_used && (rs2 == idex_q.rd))) && !i_ex_jmp;
    o_id_jmp    = ifid_valid_q && (opcode == OP_JAL) && !o_stall && !i_ex_jmp;
    o_id_target = ifid_valid_q ? (ifid_pc_q + imm_j) : '0;
  end

  // IF/ID next state: redirects squash to NOP, a stall holds, otherwise take the fetched word
  always_comb begin
    ifid_pc_d    = i_pc;
    ifid_instr_d = i_instr;
    ifid_valid_d = 1'b1;
    if (i_ex_jmp || o_id_jmp) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (o_stall) begin
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  // ID/EX next state: bubble on flush or stall, otherwise the decoded instruction
  always_comb begin
    idex_d = '0;
    if (!(i_ex_jmp || o_stall)) begin
      idex_d.valid    = ifid_valid_q;
      idex_d.pc       = ifid_pc_q;
      idex_d.opcode   = opcode;
      idex_d.funct3   = ifid_instr_q[14:12];
      idex_d.funct7b5 = ifid_instr_q[30];
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = illegal ? 5'd0 : rd;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm;
      idex_d.illegal  = illegal;
    end
  end

  // Register file write; x0 is never written
  always_comb begin
    regs_d = regs_q;
    if (i_wb_we && (i_wb_rd != 5'd0)) regs_d[i_wb_rd] = i_wb_data;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
      regs_q       <= regs_d;
    end
  end

  assign o_ex_valid    = idex_q.valid;
  assign o_ex_pc       = idex_q.pc;
  assign o_ex_opcode   = idex_q.opcode;
  assign o_ex_funct3   = idex_q.funct3;
  assign o_ex_funct7b5 = idex_q.funct7b5;
  assign o_ex_rs1      = idex_q.rs1;
  assign o_ex_rs2      = idex_q.rs2;
  assign o_ex_rd       = idex_q.rd;
  assign o_ex_rs1_data = idex_q.rs1_data;
  assign o_ex_rs2_data = idex_q.rs2_data;
  assign o_ex_imm      = idex_q.imm;
  assign o_ex_illegal  = idex_q.illegal;

endmodule
